platform_bank: RTL and testbench

PLATFORM_BANK -- requirements
Module: platform_bank

---
 rtl/platform_bank_if.sv | 28 ++
 rtl/platform_bank.sv | 181 ++++++++++++++++++
 tb/tb_platform_bank.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/platform_bank_if.sv
// Bus bundle for platform_bank: frame/scroll controls, pixel probe, slot positions and walk status.
interface platform_bank_if #(
    parameter int NUM_PLAT = 15
);
    logic                    frame_clk;
    logic                    loadplat;
    logic                    refresh_en;
    logic [7:0]              displacement;
    logic [9:0]              DrawX;
    logic [9:0]              DrawY;
    logic [10*NUM_PLAT-1:0]  platX_flat;
    logic [10*NUM_PLAT-1:0]  platY_flat;
    logic                    plat_on;
    logic [4:0]              plat_idx;
    logic                    busy;
    logic                    done;
    logic                    overrun;

    modport master (
        output frame_clk, loadplat, refresh_en, displacement, DrawX, DrawY,
        input  platX_flat, platY_flat, plat_on, plat_idx, busy, done, overrun
    );

    modport slave (
        input  frame_clk, loadplat, refresh_en, displacement, DrawX, DrawY,
        output platX_flat, platY_flat, plat_on, plat_idx, busy, done, overrun
    );
endinterface

// File: rtl/platform_bank.sv
// Scrolling platform bank: per-frame walk moves one slot per cycle downward with wrap/respawn.
// Optional PLATFORM_BANK_RANDOM_EN: respawned slots take an LFSR-derived X instead of keeping theirs.
module platform_slot #(
    parameter int         SCREEN_H = 480,
    parameter int         PLAT_W   = 64,
    parameter int         PLAT_H   = 8,
    parameter logic [9:0] LOAD_X   = '0,
    parameter logic [9:0] LOAD_Y   = '0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       upd,
    input  logic [7:0] displacement,
    input  logic [9:0] spawn_x,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hit
);
    logic [10:0] y_sum;
    logic        wrap;

    assign y_sum = {1'b0, y} + {3'b0, displacement};
    assign wrap  = (y_sum >= 11'(SCREEN_H));

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= LOAD_X;
            y <= LOAD_Y;
        end else if (upd) begin
            if (wrap) begin
                y <= 10'(y_sum - 11'(SCREEN_H));
                x <= spawn_x;
            end else begin
                y <= y_sum[9:0];
            end
        end
    end

    // 11-bit compares so X+PLAT_W near the top of the 10-bit range cannot wrap
    assign hit = ({1'b0, draw_x} >= {1'b0, x}) && ({1'b0, draw_x} < ({1'b0, x} + 11'(PLAT_W))) &&
                 ({1'b0, draw_y} >= {1'b0, y}) && ({1'b0, draw_y} < ({1'b0, y} + 11'(PLAT_H)));
endmodule

module platform_bank #(
    parameter int NUM_PLAT = 15,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PLAT_W   = 64,
    parameter int PLAT_H   = 8
) (
    input logic           Clk,
    input logic           Reset,
    platform_bank_if.slave bus
);
    localparam int         SPAN = SCREEN_W - PLAT_W;
    localparam logic [4:0] LAST = 5'(NUM_PLAT - 1);

    typedef enum logic {IDLE, WALK} state_t;

    state_t                      state, state_nxt;
    logic [4:0]                  idx, idx_nxt;
    logic                        done_q, done_nxt;
    logic                        frame_q, fedge, walking;
    logic                        overrun_q;
    logic [NUM_PLAT-1:0]         upd, hit;
    logic [NUM_PLAT-1:0][9:0]    x, y;
    logic                        hit_any, on_q;
    logic [4:0]                  hit_idx, idx_q;

    assign fedge   = bus.frame_clk & ~frame_q;
    assign walking = (state == WALK);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (fedge && bus.refresh_en) begin
                state_nxt = WALK;
                idx_nxt   = '0;
            end
            WALK: begin
                idx_nxt = idx + 5'd1;
                if (idx == LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // a load aborts the walk silently and swallows any same-cycle frame edge
        if (bus.loadplat) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            done_q    <= 1'b0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            done_q    <= done_nxt;
            frame_q   <= bus.frame_clk;
            overrun_q <= overrun_q | (fedge & walking & ~bus.loadplat);
        end
    end

`ifdef PLATFORM_BANK_RANDOM_EN
    logic [15:0] lfsr;
    logic [9:0]  rnd_x;

    always_ff @(posedge Clk) begin
        if (Reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign rnd_x = (lfsr[9:0] < 10'(SPAN)) ? lfsr[9:0] : lfsr[9:0] - 10'(SPAN);
`endif

    for (genvar i = 0; i < NUM_PLAT; i++) begin : g_slot
        localparam logic [9:0] LX = 10'((i * 96) % SPAN);
        localparam logic [9:0] LY = 10'(i * (SCREEN_H / NUM_PLAT));
        logic [9:0] spawn;

`ifdef PLATFORM_BANK_RANDOM_EN
        assign spawn = rnd_x;
`else
        assign spawn = x[i];
`endif
        assign upd[i] = walking && (idx == 5'(i)) && !bus.loadplat;

        platform_slot #(
            .SCREEN_H(SCREEN_H), .PLAT_W(PLAT_W), .PLAT_H(PLAT_H),
            .LOAD_X(LX), .LOAD_Y(LY)
        ) u_slot (
            .clk(Clk), .reset(Reset), .load(bus.loadplat), .upd(upd[i]),
            .displacement(bus.displacement), .spawn_x(spawn),
            .draw_x(bus.DrawX), .draw_y(bus.DrawY),
            .x(x[i]), .y(y[i]), .hit(hit[i])
        );
    end

    always_comb begin
        hit_any = |hit;
        hit_idx = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--)
            if (hit[i]) hit_idx = 5'(i);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            on_q  <= 1'b0;
            idx_q <= '0;
        end else begin
            on_q  <= hit_any;
            idx_q <= hit_idx;
        end
    end

    assign bus.platX_flat = x;
    assign bus.platY_flat = y;
    assign bus.plat_on    = on_q;
    assign bus.plat_idx   = idx_q;
    assign bus.busy       = walking;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_platform_bank.sv
// Randomized bench for platform_bank against a slot-position model built from the layout/scroll rules.
module tb_platform_bank;
    localparam int NP   = 15;
    localparam int H    = 480;
    localparam int SPAN = 576;
    localparam int PW   = 64;
    localparam int PH   = 8;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   mx [NP];
    int   my [NP];
    bit   xk [NP];

    always #10 clk = ~clk;

    platform_bank_if #(.NUM_PLAT(NP)) bif ();
    platform_bank #(.NUM_PLAT(NP)) dut (.Clk(clk), .Reset(rst), .bus(bif));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.frame_clk = 1'b0; bif.loadplat = 1'b0; bif.refresh_en = 1'b0;
        bif.displacement = '0; bif.DrawX = '0; bif.DrawY = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) begin mx[i] = 0; my[i] = 0; xk[i] = 1'b1; end
    endtask

    task automatic do_load();
        bif.loadplat = 1'b1;
        tick();
        bif.loadplat = 1'b0;
        for (int i = 0; i < NP; i++) begin
            my[i] = i * (H / NP);
            mx[i] = (i * 96) % SPAN;
            xk[i] = 1'b1;
        end
    endtask

    task automatic model_walk(input int d);
        for (int i = 0; i < NP; i++) begin
            if (my[i] + d >= H) begin
                my[i] = (my[i] + d) % H;
`ifdef PLATFORM_BANK_RANDOM_EN
                xk[i] = 1'b0;
`endif
            end else begin
                my[i] = my[i] + d;
            end
        end
    endtask

    task automatic run_walk(input int d, output int nbusy, output int ndone);
        nbusy = 0; ndone = 0;
        bif.displacement = 8'(d);
        bif.refresh_en = 1'b1;
        bif.frame_clk = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) bif.frame_clk = 1'b0;
            nbusy += int'(bif.busy);
            ndone += int'(bif.done);
        end
        model_walk(d);
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bif.busy); end
        tests++; if (bif.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bif.done); end
        tests++; if (bif.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", bif.overrun); end
        tests++; if (bif.plat_on !== 1'b0) begin fails++; $display("FAIL reset_plat_on got %b want 0", bif.plat_on); end
        tests++; if (bif.plat_idx !== 5'd0) begin fails++; $display("FAIL reset_plat_idx got %0d want 0", bif.plat_idx); end
        tests++; if (bif.platX_flat !== '0) begin fails++; $display("FAIL reset_platX got %h want 0", bif.platX_flat); end
        tests++; if (bif.platY_flat !== '0) begin fails++; $display("FAIL reset_platY got %h want 0", bif.platY_flat); end
    endtask

    task automatic test_load();
        do_load();
        tests++; if (bif.platY_flat[30 +: 10] !== 10'd96) begin fails++; $display("FAIL load_y3 got %0d want 96", bif.platY_flat[30 +: 10]); end
        tests++; if (bif.platX_flat[30 +: 10] !== 10'd288) begin fails++; $display("FAIL load_x3 got %0d want 288", bif.platX_flat[30 +: 10]); end
        tests++; if (bif.platY_flat[140 +: 10] !== 10'd448) begin fails++; $display("FAIL load_y14 got %0d want 448", bif.platY_flat[140 +: 10]); end
        tests++; if (bif.platX_flat[140 +: 10] !== 10'd192) begin fails++; $display("FAIL load_x14 got %0d want 192", bif.platX_flat[140 +: 10]); end
        tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL load_busy got %b want 0", bif.busy); end
        for (int i = 0; i < NP; i++) begin
            tests++; if (int'(bif.platY_flat[10*i +: 10]) != my[i]) begin fails++; $display("FAIL load_y slot %0d got %0d want %0d", i, bif.platY_flat[10*i +: 10], my[i]); end
            tests++; if (int'(bif.platX_flat[10*i +: 10]) != mx[i]) begin fails++; $display("FAIL load_x slot %0d got %0d want %0d", i, bif.platX_flat[10*i +: 10], mx[i]); end
        end
    endtask

    task automatic test_scroll();
        int nb, nd;
        do_load();
        run_walk(8, nb, nd);
        tests++; if (nb != 15) begin fails++; $display("FAIL scroll_busy_cycles got %0d want 15", nb); end
        tests++; if (nd != 1) begin fails++; $display("FAIL scroll_done_pulses got %0d want 1", nd); end
        tests++; if (bif.platY_flat[140 +: 10] !== 10'd456) begin fails++; $display("FAIL scroll_y14 got %0d want 456", bif.platY_flat[140 +: 10]); end
        tests++; if (bif.platY_flat[0 +: 10] !== 10'd8) begin fails++; $display("FAIL scroll_y0 got %0d want 8", bif.platY_flat[0 +: 10]); end
    endtask

    task automatic test_wrap();
        int nb, nd;
        do_load();
        run_walk(40, nb, nd);
        tests++; if (bif.platY_flat[140 +: 10] !== 10'd8) begin fails++; $display("FAIL wrap_y14 got %0d want 8", bif.platY_flat[140 +: 10]); end
`ifdef PLATFORM_BANK_RANDOM_EN
        tests++; if (int'(bif.platX_flat[140 +: 10]) >= SPAN) begin fails++; $display("FAIL wrap_x14 got %0d want <%0d", bif.platX_flat[140 +: 10], SPAN); end
`else
        tests++; if (bif.platX_flat[140 +: 10] !== 10'd192) begin fails++; $display("FAIL wrap_x14 got %0d want 192", bif.platX_flat[140 +: 10]); end
`endif
        tests++; if (nd != 1) begin fails++; $display("FAIL wrap_done_pulses got %0d want 1", nd); end
    endtask

    task automatic test_disp_zero();
        int nb, nd;
        do_load();
        run_walk(0, nb, nd);
        tests++; if (nb != 15) begin fails++; $display("FAIL zero_busy_cycles got %0d want 15", nb); end
        tests++; if (nd != 1) begin fails++; $display("FAIL zero_done_pulses got %0d want 1", nd); end
        for (int i = 0; i < NP; i++) begin
            tests++; if (int'(bif.platY_flat[10*i +: 10]) != i * (H / NP)) begin fails++; $display("FAIL zero_y slot %0d got %0d want %0d", i, bif.platY_flat[10*i +: 10], i * (H / NP)); end
        end
    endtask

    task automatic test_refresh_off();
        int nb = 0, nd = 0;
        bif.refresh_en = 1'b0;
        bif.frame_clk = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 0) bif.frame_clk = 1'b0;
            nb += int'(bif.busy);
            nd += int'(bif.done);
        end
        tests++; if (nb != 0) begin fails++; $display("FAIL refresh_off_busy got %0d want 0", nb); end
        tests++; if (nd != 0) begin fails++; $display("FAIL refresh_off_done got %0d want 0", nd); end
    endtask

    task automatic test_random_walks();
        int nb, nd, d;
        do_load();
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_load();
            end else begin
                d = int'($urandom_range(0, 255));
                run_walk(d, nb, nd);
                tests++; if (nb != 15 || nd != 1) begin fails++; $display("FAIL rand_walk_handshake busy=%0d done=%0d want 15/1 (d=%0d)", nb, nd, d); end
            end
            for (int i = 0; i < NP; i++) begin
                tests++; if (int'(bif.platY_flat[10*i +: 10]) != my[i]) begin fails++; $display("FAIL rand_y slot %0d got %0d want %0d", i, bif.platY_flat[10*i +: 10], my[i]); end
                if (xk[i]) begin
                    tests++; if (int'(bif.platX_flat[10*i +: 10]) != mx[i]) begin fails++; $display("FAIL rand_x slot %0d got %0d want %0d", i, bif.platX_flat[10*i +: 10], mx[i]); end
                end else begin
                    tests++; if (int'(bif.platX_flat[10*i +: 10]) >= SPAN) begin fails++; $display("FAIL rand_x_range slot %0d got %0d want <%0d", i, bif.platX_flat[10*i +: 10], SPAN); end
                end
            end
        end
    endtask

    task automatic test_overrun();
        int nd = 0, d;
        do_load();
        d = int'($urandom_range(1, 255));
        bif.displacement = 8'(d);
        bif.refresh_en = 1'b1;
        bif.frame_clk = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) bif.frame_clk = 1'b0;
            if (c == 4) bif.frame_clk = 1'b1;
            if (c == 5) bif.frame_clk = 1'b0;
            nd += int'(bif.done);
        end
        model_walk(d);
        tests++; if (nd != 1) begin fails++; $display("FAIL overrun_done_pulses got %0d want 1", nd); end
        tests++; if (bif.overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag got %b want 1", bif.overrun); end
        for (int i = 0; i < NP; i++) begin
            tests++; if (int'(bif.platY_flat[10*i +: 10]) != my[i]) begin fails++; $display("FAIL overrun_y slot %0d got %0d want %0d", i, bif.platY_flat[10*i +: 10], my[i]); end
        end
        do_load();
        for (int c = 0; c < 5; c++) tick();
        tests++; if (bif.overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got %b want 1", bif.overrun); end
        do_reset();
        tests++; if (bif.overrun !== 1'b0) begin fails++; $display("FAIL overrun_cleared got %b want 0", bif.overrun); end
    endtask

    task automatic test_load_edge();
        int nb = 0, nd = 0;
        do_load();
        bif.refresh_en = 1'b1;
        bif.displacement = 8'd8;
        bif.loadplat = 1'b1;
        bif.frame_clk = 1'b1;
        tick();
        bif.loadplat = 1'b0;
        bif.frame_clk = 1'b0;
        for (int c = 0; c < 20; c++) begin
            nb += int'(bif.busy);
            nd += int'(bif.done);
            tick();
        end
        tests++; if (nb != 0) begin fails++; $display("FAIL load_edge_busy got %0d want 0", nb); end
        tests++; if (nd != 0) begin fails++; $display("FAIL load_edge_done got %0d want 0", nd); end
        tests++; if (bif.overrun !== 1'b0) begin fails++; $display("FAIL load_edge_overrun got %b want 0", bif.overrun); end
        tests++; if (bif.platY_flat[140 +: 10] !== 10'd448) begin fails++; $display("FAIL load_edge_y14 got %0d want 448", bif.platY_flat[140 +: 10]); end
    endtask

    task automatic test_abort(input bit by_reset);
        int nd = 0;
        do_load();
        bif.displacement = 8'($urandom_range(1, 255));
        bif.refresh_en = 1'b1;
        bif.frame_clk = 1'b1;
        tick();
        bif.frame_clk = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            nd += int'(bif.done);
        end
        tests++; if (bif.busy !== 1'b1) begin fails++; $display("FAIL abort_midwalk_busy got %b want 1", bif.busy); end
        if (by_reset) begin
            do_reset();
        end else begin
            do_load();
        end
        for (int c = 0; c < 30; c++) begin
            nd += int'(bif.done);
            tick();
        end
        tests++; if (nd != 0) begin fails++; $display("FAIL abort_done got %0d want 0 (reset=%0d)", nd, by_reset); end
        tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", bif.busy); end
        for (int i = 0; i < NP; i++) begin
            tests++; if (int'(bif.platY_flat[10*i +: 10]) != my[i] || int'(bif.platX_flat[10*i +: 10]) != mx[i]) begin
                fails++; $display("FAIL abort_slot %0d got x=%0d y=%0d want x=%0d y=%0d", i, bif.platX_flat[10*i +: 10], bif.platY_flat[10*i +: 10], mx[i], my[i]);
            end
        end
    endtask

    task automatic test_hit();
        int nb, nd, k, dx, dy, eidx;
        bit eon;
        do_load();
        bif.DrawX = 10'd300; bif.DrawY = 10'd100;
        tick();
        tests++; if (bif.plat_on !== 1'b1) begin fails++; $display("FAIL hit_on got %b want 1", bif.plat_on); end
        tests++; if (bif.plat_idx !== 5'd3) begin fails++; $display("FAIL hit_idx got %0d want 3", bif.plat_idx); end
        bif.DrawY = 10'd104;
        tick();
        tests++; if (bif.plat_on !== 1'b0) begin fails++; $display("FAIL miss_on got %b want 0", bif.plat_on); end
        tests++; if (bif.plat_idx !== 5'd0) begin fails++; $display("FAIL miss_idx got %0d want 0", bif.plat_idx); end
        run_walk(int'($urandom_range(0, 31)), nb, nd);
        for (int n = 0; n < 30; n++) begin
            k  = int'($urandom_range(0, NP - 1));
            dx = mx[k] + int'($urandom_range(0, PW + 15)) - 8;
            dy = my[k] + int'($urandom_range(0, PH + 7)) - 4;
            if (dx < 0) dx = 0;
            if (dx > 1023) dx = 1023;
            if (dy < 0) dy = 0;
            if (dy > 1023) dy = 1023;
            eon = 1'b0; eidx = 0;
            for (int i = NP - 1; i >= 0; i--)
                if (dx >= mx[i] && dx < mx[i] + PW && dy >= my[i] && dy < my[i] + PH) begin
                    eon = 1'b1; eidx = i;
                end
            bif.DrawX = 10'(dx); bif.DrawY = 10'(dy);
            tick();
            tests++; if (bif.plat_on !== eon || int'(bif.plat_idx) != eidx) begin
                fails++; $display("FAIL rand_hit at (%0d,%0d) got on=%b idx=%0d want on=%b idx=%0d", dx, dy, bif.plat_on, bif.plat_idx, eon, eidx);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bif.frame_clk = 1'b0; bif.loadplat = 1'b0; bif.refresh_en = 1'b0;
        bif.displacement = '0; bif.DrawX = '0; bif.DrawY = '0;
        test_reset();
        test_load();
        test_scroll();
        test_wrap();
        test_disp_zero();
        test_refresh_off();
        test_random_walks();
        test_overrun();
        test_load_edge();
        test_abort(1'b0);
        test_abort(1'b1);
        test_hit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
